mem_access_unit: RTL and testbench

Memory-access stage of the RV32I pipeline: it consumes the EX/MEM register outputs, performs loads and stores on the data-memory bus with a request/ready handshake, aligns and extends load data by funct3, and registers the result into the MEM/WB register. While a bus access is outstanding it asserts `stall` to freeze EX/MEM and all earlier stages.

---
 rtl/rv32i_pkg.sv | 15 +
 rtl/load_store_align.sv | 85 ++++++++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: load/store funct3 codes and the memory-stage FSM states.
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mau_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane logic for RV32I loads and stores: store byte enables
// and lane replication, load lane extraction with sign/zero extension, and the
// legality check (funct3 validity, alignment, conflicting rd/wr).
module load_store_align
    import rv32i_pkg::*;
(
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_store_lanes,
    output logic [31:0] o_load_data,
    output logic        o_illegal
);

    logic        w_size_b;
    logic        w_size_h;
    logic        w_size_w;
    logic        w_f3_ok;
    logic        w_misalign;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Decode access width from funct3 and flag anything the bus must not see
    always_comb begin
        w_size_b = 1'b0;
        w_size_h = 1'b0;
        w_size_w = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: w_size_b = 1'b1;
            F3_H, F3_HU: w_size_h = 1'b1;
            F3_W:        w_size_w = 1'b1;
            default:     ;
        endcase
        // Stores have no unsigned variants, so only the low three codes are valid
        if (i_mem_wr) begin
            w_f3_ok = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);
        end else begin
            w_f3_ok = w_size_b | w_size_h | w_size_w;
        end
        w_misalign = (w_size_h & i_addr_lo[0]) | (w_size_w & (i_addr_lo != 2'b00));
        o_illegal  = (i_mem_rd | i_mem_wr) &
                     ((i_mem_rd & i_mem_wr) | ~w_f3_ok | w_misalign);
    end

    // Byte enables and store data replicated so every enabled lane carries the value
    always_comb begin
        o_be          = 4'b0000;
        o_store_lanes = '0;
        if (w_size_b) begin
            o_be          = 4'b0001 << i_addr_lo;
            o_store_lanes = {4{i_store_data[7:0]}};
        end else if (w_size_h) begin
            o_be          = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_store_lanes = {2{i_store_data[15:0]}};
        end else if (w_size_w) begin
            o_be          = 4'b1111;
            o_store_lanes = i_store_data;
        end
    end

    // Pick the addressed lane of the read word and extend it to 32 bits
    always_comb begin
        w_byte = i_load_word[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_load_word[15:8];
            2'd2:    w_byte = i_load_word[23:16];
            2'd3:    w_byte = i_load_word[31:24];
            default: w_byte = i_load_word[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'h000000, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'h0000, w_half};
            F3_W:    o_load_data = i_load_word;
            default: o_load_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I memory-access stage: issues data-memory requests from EX/MEM with a
// req/ready handshake, stalls the front of the pipeline while a request is
// outstanding, and registers the stage result into MEM/WB.
module mem_access_unit
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        reg_wr,
    input  logic        mux_reg_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] ula_res,
    input  logic [31:0] val_B,
    input  logic [4:0]  rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        access_fault,
    output logic        wb_reg_wr,
    output logic        wb_mux_reg_wr,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_ula_res,
    output logic [31:0] wb_mem_data
);

    mau_state_t  r_state;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_fault;
    logic        r_wb_reg_wr;
    logic        r_wb_mux_reg_wr;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_ula_res;
    logic [31:0] r_wb_mem_data;

    logic        w_access;
    logic        w_illegal;
    logic [3:0]  w_be;
    logic [31:0] w_store_lanes;
    logic [31:0] w_load_data;

    assign w_access = mem_rd | mem_wr;

    // EX/MEM is frozen during BUSY, so the live inputs still describe the
    // in-flight access and can drive the load extractor on completion.
    load_store_align u_align (
        .i_mem_rd      (mem_rd),
        .i_mem_wr      (mem_wr),
        .i_funct3      (funct3),
        .i_addr_lo     (ula_res[1:0]),
        .i_store_data  (val_B),
        .i_load_word   (dmem_rdata),
        .o_be          (w_be),
        .o_store_lanes (w_store_lanes),
        .o_load_data   (w_load_data),
        .o_illegal     (w_illegal)
    );

    // Stall whenever this cycle's instruction cannot leave the stage yet
    always_comb begin
        if (r_state == ST_BUSY) begin
            stall = ~dmem_ready;
        end else begin
            stall = w_access & ~w_illegal;
        end
    end

    // Stage FSM with request registers, fault pulse and MEM/WB register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_req           <= 1'b0;
            r_we            <= 1'b0;
            r_addr          <= '0;
            r_be            <= '0;
            r_wdata         <= '0;
            r_fault         <= 1'b0;
            r_wb_reg_wr     <= 1'b0;
            r_wb_mux_reg_wr <= 1'b0;
            r_wb_rd         <= '0;
            r_wb_ula_res    <= '0;
            r_wb_mem_data   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_fault <= w_access & w_illegal;
                    if (w_access && !w_illegal) begin
                        r_state         <= ST_BUSY;
                        r_req           <= 1'b1;
                        r_we            <= mem_wr;
                        r_addr          <= {ula_res[31:2], 2'b00};
                        r_be            <= w_be;
                        r_wdata         <= mem_wr ? w_store_lanes : '0;
                        r_wb_reg_wr     <= 1'b0;
                        r_wb_mux_reg_wr <= 1'b0;
                        r_wb_rd         <= '0;
                        r_wb_ula_res    <= '0;
                        r_wb_mem_data   <= '0;
                    end else begin
                        // A faulting access still retires, but must not write rd
                        r_wb_reg_wr     <= reg_wr & ~w_access;
                        r_wb_mux_reg_wr <= mux_reg_wr;
                        r_wb_rd         <= rd;
                        r_wb_ula_res    <= ula_res;
                        r_wb_mem_data   <= '0;
                    end
                end
                ST_BUSY: begin
                    r_fault <= 1'b0;
                    if (dmem_ready) begin
                        r_state         <= ST_IDLE;
                        r_req           <= 1'b0;
                        r_we            <= 1'b0;
                        r_addr          <= '0;
                        r_be            <= '0;
                        r_wdata         <= '0;
                        r_wb_reg_wr     <= reg_wr;
                        r_wb_mux_reg_wr <= mux_reg_wr;
                        r_wb_rd         <= rd;
                        r_wb_ula_res    <= ula_res;
                        r_wb_mem_data   <= mem_rd ? w_load_data : '0;
                    end else begin
                        r_wb_reg_wr     <= 1'b0;
                        r_wb_mux_reg_wr <= 1'b0;
                        r_wb_rd         <= '0;
                        r_wb_ula_res    <= '0;
                        r_wb_mem_data   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign dmem_req      = r_req;
    assign dmem_we       = r_we;
    assign dmem_addr     = r_addr;
    assign dmem_be       = r_be;
    assign dmem_wdata    = r_wdata;
    assign access_fault  = r_fault;
    assign wb_reg_wr     = r_wb_reg_wr;
    assign wb_mux_reg_wr = r_wb_mux_reg_wr;
    assign wb_rd         = r_wb_rd;
    assign wb_ula_res    = r_wb_ula_res;
    assign wb_mem_data   = r_wb_mem_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vectors with literal expectations, plus
// a per-cycle comparison against a transaction-level model of the stage.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd, mem_wr, reg_wr, mux_reg_wr;
    logic [2:0]  funct3;
    logic [31:0] ula_res, val_B;
    logic [4:0]  rd;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall, access_fault;
    logic        wb_reg_wr, wb_mux_reg_wr;
    logic [4:0]  wb_rd;
    logic [31:0] wb_ula_res, wb_mem_data;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr), .mux_reg_wr(mux_reg_wr),
        .funct3(funct3), .ula_res(ula_res), .val_B(val_B), .rd(rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall(stall), .access_fault(access_fault),
        .wb_reg_wr(wb_reg_wr), .wb_mux_reg_wr(wb_mux_reg_wr), .wb_rd(wb_rd),
        .wb_ula_res(wb_ula_res), .wb_mem_data(wb_mem_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (access-level arithmetic) ----------------
    function automatic int unsigned m_size(input logic [2:0] f3);
        return 1 << (int'(f3) % 4);
    endfunction

    function automatic bit m_legal(input logic r, input logic w, input logic [2:0] f3,
                                   input logic [31:0] a);
        if (r && w) return 1'b0;
        if (r && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b0;
        if (w && f3 > 2) return 1'b0;
        return (a % m_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned v;
        v = ((1 << m_size(f3)) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_lanes(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] res;
        int unsigned sz;
        sz = m_size(f3);
        for (int i = 0; i < 4; i++) res[8*i +: 8] = d[8*(i % sz) +: 8];
        return res;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
        longint v;
        int unsigned nbits;
        nbits = 8 * m_size(f3);
        v = longint'(word >> (8 * (a % 4)));
        if (nbits < 32) begin
            v = v & ((longint'(1) << nbits) - 1);
            if (f3 < 4 && v >= (longint'(1) << (nbits - 1))) v = v - (longint'(1) << nbits);
        end
        return v[31:0];
    endfunction

    bit          m_busy;
    logic        m_req, m_we, m_fault, m_wbrw, m_wbmux;
    logic [31:0] m_addr, m_wdata, m_wbula, m_wbmem;
    logic [3:0]  m_bev;
    logic [4:0]  m_wbrd;
    logic        m_acc, m_ok;

    always @(posedge clk) begin
        m_acc = mem_rd | mem_wr;
        m_ok  = m_legal(mem_rd, mem_wr, funct3, ula_res);
        if (rst) begin
            m_busy = 0; m_req = 0; m_we = 0; m_addr = 0; m_bev = 0; m_wdata = 0; m_fault = 0;
            m_wbrw = 0; m_wbmux = 0; m_wbrd = 0; m_wbula = 0; m_wbmem = 0;
        end else if (!m_busy) begin
            m_fault = m_acc && !m_ok;
            if (m_acc && m_ok) begin
                m_busy = 1; m_req = 1; m_we = mem_wr;
                m_addr = ula_res & ~32'h3;
                m_bev = m_be(funct3, ula_res);
                m_wdata = mem_wr ? m_lanes(funct3, val_B) : 32'h0;
                m_wbrw = 0; m_wbmux = 0; m_wbrd = 0; m_wbula = 0; m_wbmem = 0;
            end else begin
                m_wbrw = reg_wr && !m_acc; m_wbmux = mux_reg_wr; m_wbrd = rd;
                m_wbula = ula_res; m_wbmem = 0;
            end
        end else begin
            m_fault = 0;
            if (dmem_ready) begin
                m_busy = 0; m_req = 0;
                m_wbrw = reg_wr; m_wbmux = mux_reg_wr; m_wbrd = rd; m_wbula = ula_res;
                m_wbmem = mem_rd ? m_load(funct3, ula_res, dmem_rdata) : 32'h0;
            end else begin
                m_wbrw = 0; m_wbmux = 0; m_wbrd = 0; m_wbula = 0; m_wbmem = 0;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_stall", stall, m_busy ? !dmem_ready
                                           : ((mem_rd | mem_wr) && m_legal(mem_rd, mem_wr, funct3, ula_res)));
            check("m_req", dmem_req, m_req);
            check("m_fault", access_fault, m_fault);
            check("m_wb_reg_wr", wb_reg_wr, m_wbrw);
            check("m_wb_mux", wb_mux_reg_wr, m_wbmux);
            check("m_wb_rd", wb_rd, m_wbrd);
            check("m_wb_ula", wb_ula_res, m_wbula);
            check("m_wb_mem", wb_mem_data, m_wbmem);
            if (m_req) begin
                check("m_addr", dmem_addr, m_addr);
                check("m_be", dmem_be, m_bev);
                check("m_we", dmem_we, m_we);
                if (m_we) check("m_wdata", dmem_wdata, m_wdata);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        mem_rd = 0; mem_wr = 0; reg_wr = 0; mux_reg_wr = 0; funct3 = 0;
        ula_res = 0; val_B = 0; rd = 0;
    endtask

    task automatic mem_op(input logic rq, input logic wq, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] v, input logic [4:0] dst,
                          input logic rw, input int waits, input logic [31:0] rdat,
                          output int nstall, output logic bub_rw, output logic [31:0] s_addr,
                          output logic [3:0] s_be, output logic [31:0] s_wdata, output logic s_we);
        mem_rd = rq; mem_wr = wq; funct3 = f3; ula_res = a; val_B = v; rd = dst;
        reg_wr = rw; mux_reg_wr = rq; dmem_ready = 0; dmem_rdata = 0;
        nstall = 0;
        #1 if (stall) nstall++;
        tick();
        bub_rw = wb_reg_wr; s_addr = dmem_addr; s_be = dmem_be; s_wdata = dmem_wdata; s_we = dmem_we;
        for (int i = 0; i < waits; i++) begin
            #1 if (stall) nstall++;
            tick();
        end
        dmem_ready = 1; dmem_rdata = rdat;
        #1 if (stall) nstall++;
        tick();
        dmem_ready = 0; dmem_rdata = 0;
        set_nop();
    endtask

    int          ns;
    logic        bub;
    logic [31:0] sa, sw;
    logic [3:0]  sb;
    logic        swe;

    initial begin
        rst = 1; dmem_ready = 0; dmem_rdata = 0;
        set_nop();
        tick();
        chk_en = 1;
        tick();
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_be", dmem_be, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_stall", stall, 0);
        check("rst_fault", access_fault, 0);
        check("rst_wb", {wb_reg_wr, wb_mux_reg_wr, wb_rd} | wb_ula_res | wb_mem_data, 0);
        rst = 0;

        // ALU op passes straight through
        ula_res = 32'h1234; rd = 5; reg_wr = 1;
        #1 check("alu_stall", stall, 0);
        tick();
        check("alu_wb_ula", wb_ula_res, 32'h1234);
        check("alu_wb_rd", wb_rd, 5);
        check("alu_wb_rw", wb_reg_wr, 1);
        set_nop();

        // SB with three not-ready cycles
        mem_op(0, 1, 3'd0, 32'h1003, 32'h0000_00AB, 0, 0, 3, 0, ns, bub, sa, sb, sw, swe);
        check("sb_stall_cycles", ns, 4);
        check("sb_addr", sa, 32'h1000);
        check("sb_be", sb, 4'b1000);
        check("sb_wdata", sw, 32'hABAB_ABAB);
        check("sb_we", swe, 1);

        // SH to upper half
        mem_op(0, 1, 3'd1, 32'h1002, 32'h1234_CDEF, 0, 0, 1, 0, ns, bub, sa, sb, sw, swe);
        check("sh_be", sb, 4'b1100);
        check("sh_wdata", sw, 32'hCDEF_CDEF);

        // Loads with extension
        mem_op(1, 0, 3'd0, 32'h2001, 32'h0, 7, 1, 0, 32'h0000_8000, ns, bub, sa, sb, sw, swe);
        check("lb_data", wb_mem_data, 32'hFFFF_FF80);
        check("lb_rd", wb_rd, 7);
        mem_op(1, 0, 3'd4, 32'h2001, 32'h0, 7, 1, 0, 32'h0000_8000, ns, bub, sa, sb, sw, swe);
        check("lbu_data", wb_mem_data, 32'h0000_0080);
        mem_op(1, 0, 3'd5, 32'h2002, 32'h0, 7, 1, 2, 32'hBEEF_0000, ns, bub, sa, sb, sw, swe);
        check("lhu_data", wb_mem_data, 32'h0000_BEEF);
        check("lhu_be", sb, 4'b1100);
        mem_op(1, 0, 3'd1, 32'h2002, 32'h0, 7, 1, 0, 32'h8001_0000, ns, bub, sa, sb, sw, swe);
        check("lh_data", wb_mem_data, 32'hFFFF_8001);

        // Misaligned LW faults without touching the bus
        mem_rd = 1; funct3 = 3'd2; ula_res = 32'h3002; rd = 9; reg_wr = 1; mux_reg_wr = 1;
        #1 check("mis_stall", stall, 0);
        check("mis_req0", dmem_req, 0);
        tick();
        check("mis_fault", access_fault, 1);
        check("mis_wb_rw", wb_reg_wr, 0);
        check("mis_req1", dmem_req, 0);
        set_nop();
        tick();
        check("mis_fault_clr", access_fault, 0);

        // Illegal store funct3 and conflicting rd/wr
        mem_wr = 1; funct3 = 3'd4; ula_res = 32'h5000; reg_wr = 0;
        tick();
        check("sbad_fault", access_fault, 1);
        mem_rd = 1; mem_wr = 1; funct3 = 3'd0;
        tick();
        check("rdwr_fault", access_fault, 1);
        set_nop();
        tick();

        // Reset while BUSY, then a stray ready
        mem_rd = 1; funct3 = 3'd2; ula_res = 32'h2000; rd = 3; reg_wr = 1; mux_reg_wr = 1;
        tick();
        check("abort_req_busy", dmem_req, 1);
        rst = 1;
        set_nop();
        tick();
        rst = 0;
        check("abort_req", dmem_req, 0);
        check("abort_wb", {wb_reg_wr, wb_mux_reg_wr, wb_rd} | wb_ula_res | wb_mem_data, 0);
        dmem_ready = 1; dmem_rdata = 32'hFFFF_FFFF;
        #1 check("stray_stall", stall, 0);
        tick();
        check("stray_req", dmem_req, 0);
        check("stray_wb_mem", wb_mem_data, 0);
        check("stray_wb_rw", wb_reg_wr, 0);
        dmem_ready = 0; dmem_rdata = 0;

        // Back-to-back SW then LW with immediate ready
        mem_op(0, 1, 3'd2, 32'h4000, 32'hDEAD_BEEF, 0, 0, 0, 0, ns, bub, sa, sb, sw, swe);
        check("sw_stall_cycles", ns, 1);
        check("sw_bubble", bub, 0);
        check("sw_wdata", sw, 32'hDEAD_BEEF);
        check("sw_be", sb, 4'b1111);
        mem_op(1, 0, 3'd2, 32'h4000, 32'h0, 11, 1, 0, 32'hDEAD_BEEF, ns, bub, sa, sb, sw, swe);
        check("lw_stall_cycles", ns, 1);
        check("lw_bubble", bub, 0);
        check("lw_data", wb_mem_data, 32'hDEAD_BEEF);
        check("lw_wb_rw", wb_reg_wr, 1);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
